hc21_ste_bus_controller: RTL and testbench

Parametrised successor to the HC21-STE fixed address decoder. It decodes each CPU memory cycle into one of four region classes: low memory, the STEbus window, NUM_IO 16-byte I/O slots, and high memory. It drives registered active-low selects and generates CPU wait states per region. For the STEbus window it runs the DATACK handshake with a timeout and bus-error reporting. It sits between the CPU address/control pins and the on-board chip selects and STEbus master interface.

---
 rtl/hc21_ste_pkg.sv | 26 ++
 rtl/hc21_ste_wait_timer.sv | 31 +++
 rtl/hc21_ste_bus_controller.sv | 203 ++++++++++++++++++++
 tb/tb_hc21_ste_bus_controller.sv | 354 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hc21_ste_pkg.sv
// Shared types and default memory-map constants for the HC21-STE bus controller.
//   region_e : address region classes produced by the decoder
//   state_e  : bus-cycle FSM states
package hc21_ste_pkg;

  typedef enum logic [2:0] {
    LOMEM,
    STEBUS,
    IO,
    HIMEM,
    UNMAPPED
  } region_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    STE,
    HOLD
  } state_e;

  // Default page (A15:A8) boundaries of the memory map
  localparam logic [7:0] DEF_LOMEM_TOP  = 8'h3F;
  localparam logic [7:0] DEF_STEBUS_TOP = 8'hBF;
  localparam logic [7:0] DEF_IO_BASE    = 8'hC0;

endpackage

// File: rtl/hc21_ste_wait_timer.sv
// 8-bit loadable down-counter with a zero flag. Times both the local wait
// states and the STEbus DATACK timeout.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val (has priority over dec)
//   load_val   : value to load
//   dec        : decrement by one; holds at zero
//   zero       : count is zero
module hc21_ste_wait_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       dec,
  output logic       zero
);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 8'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 8'd0)) begin
      count <= count - 8'd1;
    end
  end

  assign zero = (count == 8'd0);

endmodule

// File: rtl/hc21_ste_bus_controller.sv
// HC21-STE bus controller: decodes each CPU memory cycle into low memory,
// the STEbus window, NUM_IO 16-byte I/O slots or high memory, drives
// registered active-low selects, inserts CPU wait states and runs the
// STEbus DATACK handshake with timeout / bus-error reporting.
//   sysclk, sys_rst_n : clock, asynchronous active-low reset
//   cpu_addr          : CPU A15:A4
//   cpu_mreq_n        : memory request (synchronous)
//   ste_datack_n      : STEbus data acknowledge (synchronised)
//   sel_lomem_n, sel_stebus_n, sel_io_n, sel_himem_n : region selects
//   cpu_wait_n        : CPU WAIT
//   bus_err           : one-cycle bus-error pulse
//   bus_err_count     : saturating bus-error counter
module hc21_ste_bus_controller
  import hc21_ste_pkg::*;
#(
  parameter logic [7:0] LOMEM_TOP   = DEF_LOMEM_TOP,
  parameter logic [7:0] STEBUS_TOP  = DEF_STEBUS_TOP,
  parameter logic [7:0] IO_BASE     = DEF_IO_BASE,
  parameter int         NUM_IO      = 8,
  parameter int         MEM_WAIT    = 0,
  parameter int         IO_WAIT     = 2,
  parameter int         STE_TIMEOUT = 255
) (
  input  logic              sysclk,
  input  logic              sys_rst_n,
  input  logic [11:0]       cpu_addr,
  input  logic              cpu_mreq_n,
  input  logic              ste_datack_n,
  output logic              sel_lomem_n,
  output logic              sel_stebus_n,
  output logic [NUM_IO-1:0] sel_io_n,
  output logic              sel_himem_n,
  output logic              cpu_wait_n,
  output logic              bus_err,
  output logic [7:0]        bus_err_count
);

  if (!((LOMEM_TOP < STEBUS_TOP) && (STEBUS_TOP < IO_BASE))) begin : g_bad_map
    $error("hc21_ste_bus_controller: need LOMEM_TOP < STEBUS_TOP < IO_BASE");
  end
  if ((NUM_IO < 1) || (NUM_IO > 16)) begin : g_bad_num_io
    $error("hc21_ste_bus_controller: NUM_IO must be 1..16");
  end
  if ((STE_TIMEOUT < 1) || (STE_TIMEOUT > 255)) begin : g_bad_timeout
    $error("hc21_ste_bus_controller: STE_TIMEOUT must be 1..255");
  end

  // The timer runs through zero inclusive, so N wait cycles load N-1.
  localparam logic [7:0] MEM_LOAD = 8'(MEM_WAIT - 1);
  localparam logic [7:0] IO_LOAD  = 8'(IO_WAIT - 1);
  localparam logic [7:0] STE_LOAD = 8'(STE_TIMEOUT - 1);

  function automatic region_e decode(input logic [11:0] addr);
    logic [7:0] page;
    logic [3:0] slot;
    page = addr[11:4];
    slot = addr[3:0];
    if (page <= LOMEM_TOP)       return LOMEM;
    else if (page <= STEBUS_TOP) return STEBUS;
    else if (page < IO_BASE)     return UNMAPPED;
    else if (page == IO_BASE)    return (int'(slot) < NUM_IO) ? IO : UNMAPPED;
    else                         return HIMEM;
  endfunction

  state_e              state, state_nxt;
  region_e             region;
  logic [NUM_IO-1:0]   io_onehot;
  logic                lomem_nxt, ste_nxt, himem_nxt, wait_nxt, err_nxt, err_inc;
  logic [NUM_IO-1:0]   io_nxt;
  logic                tmr_load, tmr_dec, tmr_zero;
  logic [7:0]          tmr_val;

  assign region = decode(cpu_addr);

  always_comb begin
    io_onehot = '0;
    for (int k = 0; k < NUM_IO; k++) begin
      io_onehot[k] = (int'(cpu_addr[3:0]) == k);
    end
  end

  hc21_ste_wait_timer u_timer (
    .clk      (sysclk),
    .rst_n    (sys_rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  always_comb begin
    state_nxt = state;
    lomem_nxt = sel_lomem_n;
    ste_nxt   = sel_stebus_n;
    io_nxt    = sel_io_n;
    himem_nxt = sel_himem_n;
    wait_nxt  = cpu_wait_n;
    err_nxt   = 1'b0;
    err_inc   = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = 8'd0;
    tmr_dec   = 1'b0;
    case (state)
      IDLE: begin
        if (!cpu_mreq_n) begin
          state_nxt = HOLD;
          case (region)
            LOMEM, HIMEM: begin
              if (region == LOMEM) lomem_nxt = 1'b0;
              else                 himem_nxt = 1'b0;
              if (MEM_WAIT != 0) begin
                tmr_load  = 1'b1;
                tmr_val   = MEM_LOAD;
                wait_nxt  = 1'b0;
                state_nxt = WAIT;
              end
            end
            IO: begin
              io_nxt = ~io_onehot;
              if (IO_WAIT != 0) begin
                tmr_load  = 1'b1;
                tmr_val   = IO_LOAD;
                wait_nxt  = 1'b0;
                state_nxt = WAIT;
              end
            end
            STEBUS: begin
              ste_nxt   = 1'b0;
              tmr_load  = 1'b1;
              tmr_val   = STE_LOAD;
              wait_nxt  = 1'b0;
              state_nxt = STE;
            end
            default: begin
              // Unmapped: no select, no wait, report and hold until MREQ ends
              err_nxt = 1'b1;
              err_inc = 1'b1;
            end
          endcase
        end
      end
      WAIT, STE: begin
        if (cpu_mreq_n) begin
          // CPU abandoned the cycle: drop everything silently
          lomem_nxt = 1'b1;
          ste_nxt   = 1'b1;
          io_nxt    = '1;
          himem_nxt = 1'b1;
          wait_nxt  = 1'b1;
          state_nxt = IDLE;
        end else if ((state == STE) && !ste_datack_n) begin
          // DATACK takes priority over a simultaneous timeout
          wait_nxt  = 1'b1;
          state_nxt = HOLD;
        end else if (tmr_zero) begin
          wait_nxt  = 1'b1;
          state_nxt = HOLD;
          if (state == STE) begin
            err_nxt = 1'b1;
            err_inc = 1'b1;
          end
        end else begin
          tmr_dec = 1'b1;
        end
      end
      HOLD: begin
        if (cpu_mreq_n) begin
          lomem_nxt = 1'b1;
          ste_nxt   = 1'b1;
          io_nxt    = '1;
          himem_nxt = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sysclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= IDLE;
      sel_lomem_n   <= 1'b1;
      sel_stebus_n  <= 1'b1;
      sel_io_n      <= '1;
      sel_himem_n   <= 1'b1;
      cpu_wait_n    <= 1'b1;
      bus_err       <= 1'b0;
      bus_err_count <= 8'd0;
    end else begin
      state        <= state_nxt;
      sel_lomem_n  <= lomem_nxt;
      sel_stebus_n <= ste_nxt;
      sel_io_n     <= io_nxt;
      sel_himem_n  <= himem_nxt;
      cpu_wait_n   <= wait_nxt;
      bus_err      <= err_nxt;
      if (err_inc && (bus_err_count != 8'hFF)) begin
        bus_err_count <= bus_err_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_hc21_ste_bus_controller.sv
module tb_hc21_ste_bus_controller;

  logic        sysclk;
  logic        sys_rst_n;
  logic [11:0] cpu_addr;
  logic        cpu_mreq_n;
  logic        ste_datack_n;

  logic        sel_lomem_n, sel_stebus_n, sel_himem_n, cpu_wait_n, bus_err;
  logic [7:0]  sel_io_n;
  logic [7:0]  bus_err_count;

  logic        sel_lomem_n1, sel_stebus_n1, sel_himem_n1, cpu_wait_n1, bus_err1;
  logic [3:0]  sel_io_n1;
  logic [7:0]  bus_err_count1;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int exp_cnt   = 0;

  hc21_ste_bus_controller #(.STE_TIMEOUT(10)) dut (
    .sysclk        (sysclk),
    .sys_rst_n     (sys_rst_n),
    .cpu_addr      (cpu_addr),
    .cpu_mreq_n    (cpu_mreq_n),
    .ste_datack_n  (ste_datack_n),
    .sel_lomem_n   (sel_lomem_n),
    .sel_stebus_n  (sel_stebus_n),
    .sel_io_n      (sel_io_n),
    .sel_himem_n   (sel_himem_n),
    .cpu_wait_n    (cpu_wait_n),
    .bus_err       (bus_err),
    .bus_err_count (bus_err_count)
  );

  hc21_ste_bus_controller #(.NUM_IO(4), .STE_TIMEOUT(10)) dut4 (
    .sysclk        (sysclk),
    .sys_rst_n     (sys_rst_n),
    .cpu_addr      (cpu_addr),
    .cpu_mreq_n    (cpu_mreq_n),
    .ste_datack_n  (ste_datack_n),
    .sel_lomem_n   (sel_lomem_n1),
    .sel_stebus_n  (sel_stebus_n1),
    .sel_io_n      (sel_io_n1),
    .sel_himem_n   (sel_himem_n1),
    .cpu_wait_n    (cpu_wait_n1),
    .bus_err       (bus_err1),
    .bus_err_count (bus_err_count1)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0; cpu_mreq_n = 1'b1; ste_datack_n = 1'b1; cpu_addr = 12'h000;
    #12;
    total_cnt++;
    if ({sel_lomem_n, sel_stebus_n, sel_himem_n, sel_io_n} !== 11'h7FF)
      $display("FAIL reset_sel: got %b want all ones", {sel_lomem_n, sel_stebus_n, sel_himem_n, sel_io_n});
    else pass_cnt++;
    total_cnt++;
    if ({cpu_wait_n, bus_err} !== 2'b10) $display("FAIL reset_wait_err: got %b want 10", {cpu_wait_n, bus_err});
    else pass_cnt++;
    total_cnt++;
    if (bus_err_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", bus_err_count);
    else pass_cnt++;
    #2 sys_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lomem();
    logic wait_seen;
    cpu_addr = 12'h200; cpu_mreq_n = 1'b0;
    tick();
    total_cnt++;
    if ({sel_lomem_n, sel_stebus_n, sel_himem_n, sel_io_n} !== 11'h3FF)
      $display("FAIL lomem_sel: got %b want 01111111111", {sel_lomem_n, sel_stebus_n, sel_himem_n, sel_io_n});
    else pass_cnt++;
    wait_seen = ~cpu_wait_n;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (cpu_wait_n !== 1'b1) wait_seen = 1'b1;
    end
    total_cnt++;
    if (wait_seen !== 1'b0) $display("FAIL lomem_nowait: cpu_wait_n went low, want never low");
    else pass_cnt++;
    cpu_mreq_n = 1'b1;
    tick();
    total_cnt++;
    if (sel_lomem_n !== 1'b1) $display("FAIL lomem_release: got %b want 1", sel_lomem_n);
    else pass_cnt++;
  endtask

  task automatic test_io_wait();
    int n;
    cpu_addr = 12'hC02; cpu_mreq_n = 1'b0;
    tick();
    total_cnt++;
    if (sel_io_n !== 8'b1111_1011) $display("FAIL io_sel: got %b want 11111011", sel_io_n);
    else pass_cnt++;
    n = 0;
    while (cpu_wait_n === 1'b0 && n < 50) begin n++; tick(); end
    total_cnt++;
    if (n !== 2) $display("FAIL io_wait_len: got %0d cycles want 2", n);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (sel_io_n !== 8'b1111_1011) $display("FAIL io_hold: got %b want 11111011", sel_io_n);
    else pass_cnt++;
    cpu_mreq_n = 1'b1;
    tick();
    total_cnt++;
    if (sel_io_n !== 8'hFF) $display("FAIL io_release: got %b want 11111111", sel_io_n);
    else pass_cnt++;
  endtask

  task automatic test_ste_datack();
    cpu_addr = 12'h800; cpu_mreq_n = 1'b0;
    tick();
    total_cnt++;
    if ({sel_stebus_n, cpu_wait_n} !== 2'b00) $display("FAIL ste_start: got %b want 00", {sel_stebus_n, cpu_wait_n});
    else pass_cnt++;
    repeat (4) tick();
    total_cnt++;
    if (cpu_wait_n !== 1'b0) $display("FAIL ste_waiting: got %b want 0", cpu_wait_n);
    else pass_cnt++;
    ste_datack_n = 1'b0;
    tick();
    ste_datack_n = 1'b1;
    total_cnt++;
    if ({cpu_wait_n, bus_err, sel_stebus_n} !== 3'b100)
      $display("FAIL ste_datack: got wait,err,sel=%b want 100", {cpu_wait_n, bus_err, sel_stebus_n});
    else pass_cnt++;
    cpu_mreq_n = 1'b1;
    tick();
    total_cnt++;
    if ({sel_stebus_n, bus_err_count} !== {1'b1, 8'd0})
      $display("FAIL ste_release: got sel=%b cnt=%0d want sel=1 cnt=0", sel_stebus_n, bus_err_count);
    else pass_cnt++;
  endtask

  task automatic test_ste_timeout();
    int n;
    cpu_addr = 12'h800; cpu_mreq_n = 1'b0;
    tick();
    n = 0;
    while (cpu_wait_n === 1'b0 && n < 50) begin n++; tick(); end
    exp_cnt = 1;
    total_cnt++;
    if (n !== 10) $display("FAIL to_len: got %0d cycles want 10", n);
    else pass_cnt++;
    total_cnt++;
    if ({bus_err, sel_stebus_n} !== 2'b10) $display("FAIL to_err: got err,sel=%b want 10", {bus_err, sel_stebus_n});
    else pass_cnt++;
    total_cnt++;
    if (bus_err_count !== 8'(exp_cnt)) $display("FAIL to_count: got %0d want %0d", bus_err_count, exp_cnt);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (bus_err !== 1'b0) $display("FAIL to_pulse: got %b want 0", bus_err);
    else pass_cnt++;
    cpu_mreq_n = 1'b1;
    tick();
  endtask

  task automatic test_datack_vs_timeout();
    cpu_addr = 12'h900; cpu_mreq_n = 1'b0;
    tick();
    repeat (9) tick();
    total_cnt++;
    if (cpu_wait_n !== 1'b0) $display("FAIL tie_pre: got %b want 0", cpu_wait_n);
    else pass_cnt++;
    ste_datack_n = 1'b0;
    tick();
    ste_datack_n = 1'b1;
    total_cnt++;
    if ({cpu_wait_n, bus_err} !== 2'b10) $display("FAIL tie_datack_wins: got wait,err=%b want 10", {cpu_wait_n, bus_err});
    else pass_cnt++;
    cpu_mreq_n = 1'b1;
    tick();
    total_cnt++;
    if (bus_err_count !== 8'(exp_cnt)) $display("FAIL tie_count: got %0d want %0d", bus_err_count, exp_cnt);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    cpu_addr = 12'h800; cpu_mreq_n = 1'b0;
    tick();
    repeat (3) tick();
    cpu_mreq_n = 1'b1;
    tick();
    total_cnt++;
    if ({sel_stebus_n, cpu_wait_n, bus_err} !== 3'b110)
      $display("FAIL abort: got sel,wait,err=%b want 110", {sel_stebus_n, cpu_wait_n, bus_err});
    else pass_cnt++;
    repeat (12) tick();
    total_cnt++;
    if ({bus_err_count, cpu_wait_n} !== {8'(exp_cnt), 1'b1})
      $display("FAIL abort_quiet: got cnt=%0d wait=%b want cnt=%0d wait=1", bus_err_count, cpu_wait_n, exp_cnt);
    else pass_cnt++;
  endtask

  typedef struct {
    logic [11:0] a;
    logic [2:0]  lsh;   // {lomem, stebus, himem} expected selects
    logic [7:0]  io;
    logic        err;
    logic        wt;
  } vec_t;

  task automatic test_decode_table();
    vec_t tbl[9];
    tbl[0] = '{12'h200, 3'b011, 8'hFF, 1'b0, 1'b1};
    tbl[1] = '{12'h3FF, 3'b011, 8'hFF, 1'b0, 1'b1};
    tbl[2] = '{12'h400, 3'b101, 8'hFF, 1'b0, 1'b0};
    tbl[3] = '{12'hBFF, 3'b101, 8'hFF, 1'b0, 1'b0};
    tbl[4] = '{12'hC00, 3'b111, 8'hFE, 1'b0, 1'b0};
    tbl[5] = '{12'hC07, 3'b111, 8'h7F, 1'b0, 1'b0};
    tbl[6] = '{12'hC08, 3'b111, 8'hFF, 1'b1, 1'b1};
    tbl[7] = '{12'hC10, 3'b110, 8'hFF, 1'b0, 1'b1};
    tbl[8] = '{12'hFFF, 3'b110, 8'hFF, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++) begin
      cpu_addr = tbl[i].a; cpu_mreq_n = 1'b0;
      tick();
      if (tbl[i].err) exp_cnt++;
      total_cnt++;
      if ({sel_lomem_n, sel_stebus_n, sel_himem_n, sel_io_n, bus_err, cpu_wait_n} !==
          {tbl[i].lsh, tbl[i].io, tbl[i].err, tbl[i].wt})
        $display("FAIL decode_%03h: got lsh=%b io=%b err=%b wait=%b want lsh=%b io=%b err=%b wait=%b",
                 tbl[i].a, {sel_lomem_n, sel_stebus_n, sel_himem_n}, sel_io_n, bus_err, cpu_wait_n,
                 tbl[i].lsh, tbl[i].io, tbl[i].err, tbl[i].wt);
      else pass_cnt++;
      cpu_mreq_n = 1'b1;
      tick();
      total_cnt++;
      if ({sel_lomem_n, sel_stebus_n, sel_himem_n, sel_io_n, cpu_wait_n} !== 12'hFFF)
        $display("FAIL decode_rel_%03h: got %b want all ones", tbl[i].a,
                 {sel_lomem_n, sel_stebus_n, sel_himem_n, sel_io_n, cpu_wait_n});
      else pass_cnt++;
    end
    total_cnt++;
    if (bus_err_count !== 8'(exp_cnt)) $display("FAIL decode_count: got %0d want %0d", bus_err_count, exp_cnt);
    else pass_cnt++;
  endtask

  task automatic test_num_io4();
    cpu_addr = 12'hC05; cpu_mreq_n = 1'b0;
    tick();
    total_cnt++;
    if ({sel_lomem_n1, sel_stebus_n1, sel_himem_n1, sel_io_n1, bus_err1, cpu_wait_n1} !== 9'b111_1111_11)
      $display("FAIL io4_unmapped: got %b want 111111111",
               {sel_lomem_n1, sel_stebus_n1, sel_himem_n1, sel_io_n1, bus_err1, cpu_wait_n1});
    else pass_cnt++;
    total_cnt++;
    if (sel_io_n !== 8'b1101_1111) $display("FAIL io8_slot5: got %b want 11011111", sel_io_n);
    else pass_cnt++;
    cpu_mreq_n = 1'b1;
    tick();
    cpu_addr = 12'hC03; cpu_mreq_n = 1'b0;
    tick();
    total_cnt++;
    if ({sel_io_n1, bus_err1} !== 5'b0111_0) $display("FAIL io4_slot3: got io=%b err=%b want io=0111 err=0", sel_io_n1, bus_err1);
    else pass_cnt++;
    cpu_mreq_n = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    cpu_addr = 12'h123; cpu_mreq_n = 1'b0;
    tick();
    cpu_mreq_n = 1'b1;
    tick();
    cpu_addr = 12'hD00; cpu_mreq_n = 1'b0;
    tick();
    total_cnt++;
    if ({sel_lomem_n, sel_himem_n} !== 2'b10) $display("FAIL b2b: got lomem,himem=%b want 10", {sel_lomem_n, sel_himem_n});
    else pass_cnt++;
    cpu_mreq_n = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_cycle();
    cpu_addr = 12'h800; cpu_mreq_n = 1'b0;
    tick();
    repeat (2) tick();
    sys_rst_n = 1'b0;
    #2;
    total_cnt++;
    if ({sel_stebus_n, cpu_wait_n, bus_err_count} !== {2'b11, 8'd0})
      $display("FAIL rst_mid: got sel=%b wait=%b cnt=%0d want sel=1 wait=1 cnt=0", sel_stebus_n, cpu_wait_n, bus_err_count);
    else pass_cnt++;
    exp_cnt = 0;
    cpu_mreq_n = 1'b1;
    #2 sys_rst_n = 1'b1;
    tick();
    cpu_addr = 12'h200; cpu_mreq_n = 1'b0;
    tick();
    total_cnt++;
    if ({sel_lomem_n, sel_stebus_n, cpu_wait_n} !== 3'b011)
      $display("FAIL rst_after: got lomem,ste,wait=%b want 011", {sel_lomem_n, sel_stebus_n, cpu_wait_n});
    else pass_cnt++;
    cpu_mreq_n = 1'b1;
    tick();
  endtask

  task automatic test_saturation();
    int n;
    int bad;
    bad = 0;
    for (int c = 0; c < 300; c++) begin
      cpu_addr = 12'h800; cpu_mreq_n = 1'b0;
      tick();
      n = 0;
      while (cpu_wait_n === 1'b0 && n < 50) begin n++; tick(); end
      if (n != 10 || bus_err !== 1'b1) bad++;
      if (c == 0) begin
        total_cnt++;
        if (bus_err_count !== 8'd1) $display("FAIL sat_first: got %0d want 1", bus_err_count);
        else pass_cnt++;
      end
      cpu_mreq_n = 1'b1;
      tick();
    end
    total_cnt++;
    if (bad !== 0) $display("FAIL sat_timeouts: got %0d bad timeout cycles want 0", bad);
    else pass_cnt++;
    total_cnt++;
    if (bus_err_count !== 8'd255) $display("FAIL sat_count: got %0d want 255", bus_err_count);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_lomem();
    test_io_wait();
    test_ste_datack();
    test_ste_timeout();
    test_datack_vs_timeout();
    test_abort();
    test_decode_table();
    test_num_io4();
    test_back_to_back();
    test_reset_mid_cycle();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
